// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per clk.
// Optional even-parity trailer bit is compiled in when the macro PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d   = parity_q;
`endif
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d  = din;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef PISO_PARITY_EN
          parity_d = ^din;
`endif
        end
      end

      SHIFT: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        // The outgoing bit always sits at the end the register shifts away from.
        if (MSB_FIRST) begin
          sout    = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
          sout    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout       = parity_q;
        state_d    = IDLE;
        done_d     = 1'b1;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are checked
// every cycle against a queue-of-frame-bits model, plus literal checks of the documented scenarios.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         load_valid;
  logic         lr_m, so_m, sv_m, busy_m, done_m;
  logic         lr_l, so_l, sv_l, busy_l, done_l;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(lr_m), .sout(so_m), .sout_valid(sv_m), .busy(busy_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(lr_l), .sout(so_l), .sout_valid(sv_l), .busy(busy_l), .done(done_l)
  );

  // Downstream 4-stage shift register fed by the MSB-first serializer; ds[1] is out1.
  logic [4:1] ds = '0;
  always @(posedge clk) ds <= {ds[3:1], so_m};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Model: each frame is the list of bits still to emit; the head is this cycle's sout.
  bit q_m[$];
  bit q_l[$];
  bit done_exp = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      q_m.delete();
      q_l.delete();
      done_exp = 1'b0;
    end else if (q_m.size() != 0) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
      done_exp = (q_m.size() == 0);
    end else begin
      done_exp = 1'b0;
      if (load_valid) begin
        for (int k = 0; k < W; k++) begin
          q_m.push_back(din[W-1-k]);
          q_l.push_back(din[k]);
        end
`ifdef PISO_PARITY_EN
        q_m.push_back(^din);
        q_l.push_back(^din);
`endif
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      logic act_exp;
      act_exp = (q_m.size() != 0);
      check("sout_valid_m", {31'd0, sv_m}, {31'd0, act_exp});
      check("sout_valid_l", {31'd0, sv_l}, {31'd0, act_exp});
      check("sout_m", {31'd0, so_m}, {31'd0, act_exp ? q_m[0] : 1'b0});
      check("sout_l", {31'd0, so_l}, {31'd0, act_exp ? q_l[0] : 1'b0});
      check("load_ready", {30'd0, lr_m, lr_l}, {30'd0, !act_exp, !act_exp});
      check("busy", {30'd0, busy_m, busy_l}, {30'd0, act_exp, act_exp});
      check("done", {30'd0, done_m, done_l}, {30'd0, done_exp, done_exp});
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] bm, bl;

    reset = 1'b0;
    load_valid = 1'b1;
    din = 4'b1011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_load_ready", {31'd0, lr_m}, 32'd1);
    check("rst_sout", {31'd0, so_m}, 32'd0);
    check("rst_sout_valid", {31'd0, sv_m}, 32'd0);
    check("rst_busy", {31'd0, busy_m}, 32'd0);
    check("rst_done", {31'd0, done_m}, 32'd0);
    check_en = 1'b1;

    // Single accept of 1011
    go();
    reset = 1'b1;
    load_valid = 1'b1;
    din = 4'b1011;
    go();
    load_valid = 1'b0;
    bm = '0;
    bl = '0;
    for (int c = 1; c <= F; c++) begin
      @(negedge clk);
      if (c <= W) begin
        bm = {bm[2:0], so_m};
        bl = {bl[2:0], so_l};
      end
`ifdef PISO_PARITY_EN
      if (c == F) check("parity_bit", {31'd0, so_m}, 32'd1);
`endif
      go();
    end
    check("msb_first_bits", {28'd0, bm}, 32'h0000000b);
    check("lsb_first_bits", {28'd0, bl}, 32'h0000000d);
    @(negedge clk);
    check("frame_done", {31'd0, done_m}, 32'd1);
`ifdef PISO_PARITY_EN
    check("chain_out1to4", {28'd0, ds[1], ds[2], ds[3], ds[4]}, 32'h0000000e);
`else
    check("chain_out1to4", {28'd0, ds[1], ds[2], ds[3], ds[4]}, 32'h0000000d);
`endif

    // Held valid: 0110 then 1001
    go();
    load_valid = 1'b1;
    din = 4'b0110;
    go();
    din = 4'b1001;
    for (int c = 1; c <= F; c++) begin
      @(negedge clk);
      check("held_ready_low", {31'd0, lr_m}, 32'd0);
      go();
    end
    @(negedge clk);
    check("held_second_accept", {30'd0, lr_m, done_m}, 32'd3);
    go();
    load_valid = 1'b0;
    bm = '0;
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      bm = {bm[2:0], so_m};
      go();
    end
    check("held_second_bits", {28'd0, bm}, 32'h00000009);
    repeat (F) go();

    // Mid-frame reset
    load_valid = 1'b1;
    din = 4'b1011;
    go();
    load_valid = 1'b0;
    go();
    reset = 1'b0;
    go();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_flags", {29'd0, sv_m, busy_m, done_m}, 32'd0);
    go();
    @(negedge clk);
    check("midrst_no_done", {31'd0, done_m}, 32'd0);
    load_valid = 1'b1;
    din = 4'b1111;
    go();
    load_valid = 1'b0;
    bm = '0;
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      bm = {bm[2:0], so_m};
      go();
    end
    check("after_rst_bits", {28'd0, bm}, 32'h0000000f);
    repeat (F) go();

    // Randomized traffic, occasional resets, X on din while idle-valid is low
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      load_valid = 1'($urandom_range(0, 1));
      if (load_valid || $urandom_range(0, 1) == 0)
        din = W'($urandom);
      else
        din = 'x;
      go();
    end
    reset = 1'b1;
    load_valid = 1'b0;
    repeat (F + 2) go();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
